// File: rtl/mux_4_1_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_4_1_if
// Description : Bus bundle for the 4:1 mux (select, four data inputs,
//               combinational and registered outputs).
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_4_1_if #(
  parameter int BUS_WIDTH = 16
);
  logic [1:0]           sel;
  logic [BUS_WIDTH-1:0] in00;
  logic [BUS_WIDTH-1:0] in01;
  logic [BUS_WIDTH-1:0] in10;
  logic [BUS_WIDTH-1:0] in11;
  logic [BUS_WIDTH-1:0] out;
  logic [BUS_WIDTH-1:0] out_q;
  logic [1:0]           sel_q;

  modport master (
    output sel, in00, in01, in10, in11,
    input  out, out_q, sel_q
  );

  modport slave (
    input  sel, in00, in01, in10, in11,
    output out, out_q, sel_q
  );
endinterface
`default_nettype wire

// File: rtl/mux_4_1.sv
`default_nettype none
// ============================================================================
// Module      : mux_4_1
// Description : 4:1 data mux with a combinational output plus a one-cycle
//               registered copy of the output and the select code.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4_1 #(
  parameter int BUS_WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  mux_4_1_if.slave bus
);

  logic [BUS_WIDTH-1:0] w_out;
  logic [BUS_WIDTH-1:0] r_out_q;
  logic [1:0]           r_sel_q;

  // An unknown select yields all-X rather than silently picking an input.
  always_comb begin
    w_out = {BUS_WIDTH{1'bx}};
    case (bus.sel)
      2'b00:   w_out = bus.in00;
      2'b01:   w_out = bus.in01;
      2'b10:   w_out = bus.in10;
      2'b11:   w_out = bus.in11;
      default: w_out = {BUS_WIDTH{1'bx}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_q <= '0;
      r_sel_q <= 2'b00;
    end else begin
      r_out_q <= w_out;
      r_sel_q <= bus.sel;
    end
  end

  assign bus.out   = w_out;
  assign bus.out_q = r_out_q;
  assign bus.sel_q = r_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_4_1.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_4_1
// Description : Self-checking bench for mux_4_1 at widths 1, 16 and 32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_4_1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux_4_1_if #(.BUS_WIDTH(1))  b1 ();
  mux_4_1_if #(.BUS_WIDTH(16)) b16 ();
  mux_4_1_if #(.BUS_WIDTH(32)) b32 ();

  mux_4_1 #(.BUS_WIDTH(1))  u_w1  (.clk(clk), .rst(rst), .bus(b1.slave));
  mux_4_1 #(.BUS_WIDTH(16)) u_w16 (.clk(clk), .rst(rst), .bus(b16.slave));
  mux_4_1 #(.BUS_WIDTH(32)) u_w32 (.clk(clk), .rst(rst), .bus(b32.slave));

  // Reference: index the four inputs by the select code.
  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] c,
                                       input logic [31:0] d);
    logic [31:0] arr [4];
    arr[0] = a; arr[1] = b; arr[2] = c; arr[3] = d;
    return arr[s];
  endfunction

  logic [31:0] d00, d01, d10, d11;
  logic [1:0]  dsel;

  task automatic drive(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    dsel = s; d00 = a; d01 = b; d10 = c; d11 = d;
    b1.sel  = s; b1.in00  = a[0];     b1.in01  = b[0];     b1.in10  = c[0];     b1.in11  = d[0];
    b16.sel = s; b16.in00 = a[15:0];  b16.in01 = b[15:0];  b16.in10 = c[15:0];  b16.in11 = d[15:0];
    b32.sel = s; b32.in00 = a;        b32.in01 = b;        b32.in10 = c;        b32.in11 = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(2'b11, 32'h5, 32'hA, 32'h3, 32'h2);
    tick();
    tick();
    checks++;
    if (b16.out_q !== 16'h0000 || b16.sel_q !== 2'b00) begin
      errors++;
      $display("FAIL reset_w16 out_q=%h sel_q=%b required 0000/00", b16.out_q, b16.sel_q);
    end
    checks++;
    if (b32.out_q !== 32'h0 || b1.out_q !== 1'b0 || b32.sel_q !== 2'b00 || b1.sel_q !== 2'b00) begin
      errors++;
      $display("FAIL reset_w1_w32 out_q=%h/%b sel_q=%b/%b required 0/0 00/00",
               b32.out_q, b1.out_q, b32.sel_q, b1.sel_q);
    end
    checks++;
    if (b16.out !== 16'h0002) begin
      errors++;
      $display("FAIL reset_comb_live out=%h required 0002", b16.out);
    end
  endtask

  task automatic test_comb_select();
    logic [15:0] exp [4];
    exp[0] = 16'h0005; exp[1] = 16'h000A; exp[2] = 16'h0003; exp[3] = 16'h0002;
    for (int s = 0; s < 4; s++) begin
      drive(2'(s), 32'h5, 32'hA, 32'h3, 32'h2);
      #10;
      checks++;
      if (b16.out !== exp[s]) begin
        errors++;
        $display("FAIL comb_sel%0d out=%h required %h", s, b16.out, exp[s]);
      end
    end
    drive(2'b01, 32'hFFFF, 32'hA, 32'hFFFF, 32'hFFFF);
    #1;
    checks++;
    if (b16.out !== 16'h000A) begin
      errors++;
      $display("FAIL comb_unselected out=%h required 000a", b16.out);
    end
    drive(2'b01, 32'hFFFF, 32'h1234, 32'hFFFF, 32'hFFFF);
    #1;
    checks++;
    if (b16.out !== 16'h1234) begin
      errors++;
      $display("FAIL comb_selected_change out=%h required 1234", b16.out);
    end
  endtask

  task automatic test_registered();
    rst = 1'b1;
    drive(2'b00, 32'h5, 32'hA, 32'h3, 32'h2);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    drive(2'b10, 32'h5, 32'hA, 32'h3, 32'h2);
    tick();
    checks++;
    if (b16.out_q !== 16'h0003 || b16.sel_q !== 2'b10) begin
      errors++;
      $display("FAIL first_capture out_q=%h sel_q=%b required 0003/10", b16.out_q, b16.sel_q);
    end
    @(negedge clk);
    drive(2'b11, 32'h5, 32'hA, 32'h3, 32'h2);
    #1;
    checks++;
    if (b16.out !== 16'h0002 || b16.out_q !== 16'h0003) begin
      errors++;
      $display("FAIL sel_change_between_edges out=%h out_q=%h required 0002/0003", b16.out, b16.out_q);
    end
    tick();
    checks++;
    if (b16.out_q !== 16'h0002 || b16.sel_q !== 2'b11) begin
      errors++;
      $display("FAIL sel_change_capture out_q=%h sel_q=%b required 0002/11", b16.out_q, b16.sel_q);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (b16.out_q !== 16'h0002 || b16.sel_q !== 2'b11) begin
      errors++;
      $display("FAIL reset_not_async out_q=%h sel_q=%b required 0002/11", b16.out_q, b16.sel_q);
    end
    tick();
    checks++;
    if (b16.out_q !== 16'h0000 || b16.sel_q !== 2'b00 || b16.out !== 16'h0002) begin
      errors++;
      $display("FAIL midop_reset out_q=%h sel_q=%b out=%h required 0000/00/0002",
               b16.out_q, b16.sel_q, b16.out);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (b16.out_q !== 16'h0002 || b16.sel_q !== 2'b11) begin
      errors++;
      $display("FAIL after_reset_capture out_q=%h sel_q=%b required 0002/11", b16.out_q, b16.sel_q);
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    logic [31:0] eq;
    logic [1:0]  es;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 9) == 0);
      drive(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
      e  = pick(dsel, d00, d01, d10, d11);
      eq = rst ? 32'h0 : e;
      es = rst ? 2'b00 : dsel;
      #1;
      checks++;
      if (b32.out !== e || b16.out !== e[15:0] || b1.out !== e[0]) begin
        errors++;
        $display("FAIL rand_comb iter %0d out=%h/%h/%b required %h", i, b32.out, b16.out, b1.out, e);
      end
      tick();
      checks++;
      if (b32.out_q !== eq || b16.out_q !== eq[15:0] || b1.out_q !== eq[0] ||
          b32.sel_q !== es || b16.sel_q !== es || b1.sel_q !== es) begin
        errors++;
        $display("FAIL rand_reg iter %0d out_q=%h/%h/%b sel_q=%b/%b/%b required %h sel %b",
                 i, b32.out_q, b16.out_q, b1.out_q, b32.sel_q, b16.sel_q, b1.sel_q, eq, es);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_walking();
    logic [31:0] v [4];
    logic [31:0] e;
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 32; b++) begin
        for (int s = 0; s < 4; s++) begin
          for (int j = 0; j < 4; j++) v[j] = (j == k) ? (32'h1 << b) : 32'h0;
          drive(2'(s), v[0], v[1], v[2], v[3]);
          e = pick(2'(s), v[0], v[1], v[2], v[3]);
          #1;
          checks++;
          if (b32.out !== e || b16.out !== e[15:0] || b1.out !== e[0]) begin
            errors++;
            $display("FAIL walk in%0d bit%0d sel%0d out=%h/%h/%b required %h",
                     k, b, s, b32.out, b16.out, b1.out, e);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    test_reset();
    test_comb_select();
    test_registered();
    test_random();
    test_walking();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_4_1.md
MUX_4_1 -- requirements
Module: mux_4_1

Interface
REQ-001 Parameter BUS_WIDTH, default 16: bit width of every data input and data output; SHALL support any value >= 1.
REQ-002 clk  input  1  single clock; all sequential state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sel  input  2  select code choosing one of four data inputs.
REQ-005 in00  input  BUS_WIDTH  data routed when sel = 2'b00.
REQ-006 in01  input  BUS_WIDTH  data routed when sel = 2'b01.
REQ-007 in10  input  BUS_WIDTH  data routed when sel = 2'b10.
REQ-008 in11  input  BUS_WIDTH  data routed when sel = 2'b11.
REQ-009 out  output  BUS_WIDTH  combinational selected data.
REQ-010 out_q  output  BUS_WIDTH  registered copy of out.
REQ-011 sel_q  output  2  registered copy of sel, aligned with out_q.

Function
REQ-012 out SHALL equal in00/in01/in10/in11 for sel = 00/01/10/11 respectively; pure combinational, zero-cycle latency, independent of clk and rst.
REQ-013 out SHALL update within the same delta/time step as any change on sel or on the currently selected input; changes on unselected inputs SHALL NOT affect out.
REQ-014 Full-width routing: every bit of the selected input SHALL appear unmodified at the same bit position of out; no truncation, extension or inversion.
REQ-015 If sel contains X or Z in simulation, out SHALL be all X (no silent default to any input).
REQ-016 On each rising clk with rst = 0: out_q <= out, sel_q <= sel; latency of out_q and sel_q relative to out/sel is exactly 1 cycle.
REQ-017 Simultaneous change of sel and selected data before a clock edge: out_q SHALL capture the value out has at that edge (new sel, new data).
REQ-018 No handshake, no internal state beyond out_q and sel_q; block SHALL NOT generate or gate clocks.

Reset
REQ-019 On a rising clk with rst = 1: out_q <= 0 (all BUS_WIDTH bits), sel_q <= 2'b00.
REQ-020 rst SHALL NOT affect out; combinational path stays live during reset.
REQ-021 rst has priority over capture; asserting rst mid-operation SHALL clear registers at the next edge regardless of sel/data; first capture occurs on the first edge with rst = 0.
REQ-022 No asynchronous behaviour: rst asserted between edges SHALL NOT change out_q or sel_q until the next rising clk.

Verification
REQ-023 BUS_WIDTH=16, in00=0005, in01=000A, in10=0003, in11=0002; sel stepped 00,01,10,11 every 10 time units -> out = 0005, 000A, 0003, 0002 in each interval, no clock required.
REQ-024 sel held 01; change in00/in10/in11 to FFFF -> out stays 000A; change in01 to 1234 -> out = 1234 immediately.
REQ-025 rst=1 for two edges with in values as REQ-023 -> out_q = 0000, sel_q = 00; deassert, sel=10 -> after one edge out_q = 0003, sel_q = 10.
REQ-026 Change sel 10->11 between edges -> out = 0002 immediately, out_q = 0003 until the next edge, then 0002.
REQ-027 Assert rst for one edge while sel=11 -> out_q = 0000 after that edge, out stays 0002; deassert -> out_q = 0002 one edge later.
REQ-028 BUS_WIDTH=1 and BUS_WIDTH=32 builds; walking-ones on each input across all sel codes -> out bit-exact match to selected input.
